// File: rtl/mux_nx1_rr_reg.sv
// N-input registered multiplexer with valid/ready handshakes on each input and on the output.
// The source is chosen by an external select or by round-robin among valid inputs.
module mux_nx1_rr_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_any;
    logic [NUM_IN-1:0] grant;
    logic              load;
    int                cand;

    assign load = ~out_valid | out_ready;

    // The round-robin search begins one past the last granted channel and wraps upward.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        if (mode) begin
            for (int k = 0; k < NUM_IN; k++) begin
                cand = (int'(ptr) + 1 + k) % NUM_IN;
                if (!grant_any && in_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = SEL_W'(cand);
                end
            end
        end else if (int'(sel) < NUM_IN) begin
            grant_any = in_valid[sel];
            grant_idx = sel;
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign in_ready = reset ? '0 : (grant & {NUM_IN{load}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SEL_W'(NUM_IN - 1);
        end else if (load) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_src   <= grant_idx;
                if (mode) begin
                    ptr <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_nx1_rr_reg.md
# mux_nx1_rr_reg

Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. Selects a source either from an external select (fixed mode) or by round-robin arbitration among valid inputs (RR mode), and registers the chosen word with its source index. It is the next generation of the 4x1 32-bit datapath mux. It sits between operand sources (register file, sequential multiplier result, immediate, ALU feedback) and the ALU operand/result path where sources produce data on different cycles.

## Interface
- WIDTH, 32, data width in bits (>=1)
- NUM_IN, 4, number of input channels (>=2)
- SEL_W, $clog2(NUM_IN), derived index width; not overridden
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_data  input  NUM_IN*WIDTH  packed inputs; channel i at [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  per-channel valid
- in_ready  output  NUM_IN  per-channel ready; combinational
- mode  input  1  0 = fixed select via sel, 1 = round-robin
- sel  input  SEL_W  channel index in fixed mode; values >= NUM_IN select nothing
- out_data  output  WIDTH  registered selected word
- out_src  output  SEL_W  registered index of channel that supplied out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accepts out_data this cycle

## Operation
- Single-entry output register. `load = ~out_valid | out_ready`.
- Grant (combinational, at most one bit set):
  - Fixed mode: grant[sel] = in_valid[sel] when sel < NUM_IN, otherwise no grant.
  - RR mode: search in_valid starting at index (ptr+1) mod NUM_IN, wrapping upward. Grant the first valid channel. No valid inputs means no grant.
- in_ready[i] = grant[i] & load. Inputs that are not granted see in_ready=0 and must hold their data and valid.
- Transfer on channel i when in_valid[i] & in_ready[i]. On the next edge: out_data <= channel i data, out_src <= i, out_valid <= 1.
- Load with no grant: out_valid <= 0 (output drained). out_data and out_src keep their last values.
- out_valid=1 & out_ready=0: the register holds and no input is accepted.
- ptr (SEL_W bits) updates to i only on an accepted transfer in RR mode. It is unchanged in fixed mode and on idle cycles.
- Mode and sel are sampled each cycle. A change affects only the next grant. A word already held is never altered.
- Fairness: in RR mode with all inputs continuously valid and out_ready=1, the grant order is 0,1,…,NUM_IN-1,0,… with one word per cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=NUM_IN-1 (the first RR search starts at channel 0). in_ready=0 while reset is asserted.
- Reset asserted mid-transfer: the held word is discarded. After reset deasserts, behaviour is as from power-up.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Simultaneous consume and load: out_valid stays 1 and the new word replaces the old on the same edge, with no bubble.
- in_ready depends combinationally on in_valid, mode, sel, ptr, out_valid and out_ready. There is no path from in_ready to any input.
- Wrap-around: ptr=NUM_IN-1 searches from 0. A grant of NUM_IN-1 sets ptr back to NUM_IN-1.

## Test plan
- Fixed mode, WIDTH=32, NUM_IN=4, inputs 0,1,8,16 all valid, out_ready=1, sel stepping 0→1→2→3 one per cycle -> out_data 0,1,8,16 with out_src 0,1,2,3, each one cycle after its sel.
- RR mode, all four valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 and out_valid continuously 1 after the first cycle.
- RR mode, only channels 1 and 3 valid -> out_src alternates 1,3,1,3. in_ready[0] and in_ready[2] stay 0.
- Backpressure: out_valid=1 holding 8 with out_ready=0 for 3 cycles -> out_data stays 8 and all in_ready=0. Raising out_ready loads the next word in the same cycle with no bubble.
- Fixed mode with sel=2 and in_valid[2]=0, or sel=5 with NUM_IN=5 -> no grant, and out_valid drops to 0 after the held word is consumed.
- Reset asserted asynchronously while out_valid=1 mid-sequence -> out_valid, out_data and out_src go to 0 immediately. After release, RR mode grants channel 0 first.
